// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_if
//  Brief    : Byte-stream and instruction-memory write bundle for imem_loader.
//  Revision : 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Length-prefixed byte stream to big-endian 32-bit instruction
//             words; optional trailing XOR checksum (IMEM_LOADER_CHECKSUM_EN).
//  Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 101,
    parameter int ADDR_W = 7
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LEN_HI = 3'd1;
    localparam logic [2:0] c_LEN_LO = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CSUM   = 3'd4;
`endif
    localparam logic [2:0] c_DONE   = 3'd5;
    localparam logic [2:0] c_ERROR  = 3'd6;
    localparam logic [15:0] c_DEPTH = 16'(DEPTH);

    logic [2:0]        r_state;
    logic [7:0]        r_len_hi;
    logic [1:0]        r_cnt;
    logic [15:0]       r_idx;
    logic [23:0]       r_word;
    logic              r_fin;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_take;
    logic [15:0] w_n;
    logic        w_last;

    assign w_take = r_in_ready & bus.in_valid;
    assign w_n    = {r_len_hi, bus.in_data};
    assign w_last = (r_idx == r_word_count - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_len_hi     <= 8'd0;
            r_cnt        <= 2'd0;
            r_idx        <= 16'd0;
            r_word       <= 24'd0;
            r_fin        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            // Successful finish without a checksum byte: busy covers the final
            // write cycle, then hands over to done on the following edge.
            if (r_fin) begin
                r_fin  <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            case (r_state)
                c_IDLE, c_DONE, c_ERROR: begin
                    if (bus.start && !r_busy) begin
                        r_state    <= c_LEN_HI;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cnt      <= 2'd0;
                        r_idx      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                c_LEN_HI: begin
                    if (w_take) begin
                        r_len_hi <= bus.in_data;
                        r_state  <= c_LEN_LO;
                    end
                end
                c_LEN_LO: begin
                    if (w_take) begin
                        r_word_count <= w_n;
                        if (w_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= c_CSUM;
`else
                            r_state    <= c_DONE;
                            r_in_ready <= 1'b0;
                            r_fin      <= 1'b1;
`endif
                        end else if (w_n > c_DEPTH) begin
                            r_state    <= c_ERROR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= c_DATA;
                        end
                    end
                end
                c_DATA: begin
                    if (w_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.in_data;
`endif
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_idx[ADDR_W-1:0];
                            r_mem_wdata <= {r_word, bus.in_data};
                            r_idx       <= r_idx + 16'd1;
                            if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state    <= c_CSUM;
`else
                                r_state    <= c_DONE;
                                r_in_ready <= 1'b0;
                                r_fin      <= 1'b1;
`endif
                            end
                        end else begin
                            r_word <= {r_word[15:0], bus.in_data};
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                c_CSUM: begin
                    if (w_take) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= c_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.word_count = r_word_count;
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Brief    : Self-checking bench for imem_loader (table, directed, random).
//  Revision : 1.0
// ============================================================================
module tb_imem_loader;
    localparam int DEPTH  = 101;
    localparam int ADDR_W = 7;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    // Write observer: every strobe is logged; a strobe outside busy, or with
    // done already up, is a protocol violation.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at a negedge; a byte is counted as sent when in_ready is seen high
    // while it is presented, because the next rising edge consumes it.
    task automatic send_bytes(input logic [7:0] q[$], input int gap_pct, input int start_at);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < q.size() && cyc < 4000) begin
            bus.start = (i == start_at);
            if (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = q[i];
                if (bus.in_ready === 1'b1) i++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("stream accepted", i, q.size());
    endtask

    task automatic build(input int n, input bit bad, output logic [7:0] q[$]);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        q = {};
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x ^= b;
                q.push_back(b);
            end
            if (CS) q.push_back(bad ? (x ^ 8'h01) : x);
        end
    endtask

    // Reference: expected result of a complete stream from its byte list.
    task automatic check_load(input string tag, input logic [7:0] q[$]);
        int n;
        int nw;
        bit exp_err;
        logic [7:0] x;
        n = int'({q[0], q[1]});
        exp_err = (n > DEPTH);
        nw = exp_err ? 0 : n;
        x = 8'd0;
        if (!exp_err) for (int i = 0; i < 4 * n; i++) x ^= q[2 + i];
        if (CS && !exp_err && q[2 + 4 * n] !== x) exp_err = 1'b1;
        check({tag, " error"}, 32'(bus.error), 32'(exp_err));
        check({tag, " done"}, 32'(bus.done), 32'(!exp_err));
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, " word_count"}, 32'(bus.word_count), 32'(n));
        check({tag, " writes"}, wr_addr_q.size(), nw);
        for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
            check({tag, " addr"}, 32'(wr_addr_q[k]), 32'(k));
            check({tag, " data"}, wr_data_q[k],
                  {q[2 + 4 * k], q[3 + 4 * k], q[4 + 4 * k], q[5 + 4 * k]});
        end
    endtask

    task automatic run_load(input string tag, input logic [7:0] q[$], input int gap, input int start_at);
        wr_addr_q = {};
        wr_data_q = {};
        pulse_start();
        send_bytes(q, gap, start_at);
        repeat (3) @(negedge clk);
        check_load(tag, q);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
        check({tag, " done"}, 32'(bus.done), 32'd0);
        check({tag, " error"}, 32'(bus.error), 32'd0);
        check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, " word_count"}, 32'(bus.word_count), 32'd0);
    endtask

    typedef struct {
        int n;
        int gap;
        bit bad;
        bit exp_done;
        bit exp_error;
        int exp_writes;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] q[$];
        logic [7:0] spec2[$];
        int n;

        vecs[0] = '{n: 2,         gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 2};
        vecs[1] = '{n: 0,         gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 0};
        vecs[2] = '{n: 0,         gap: 0,  bad: 1'b1, exp_done: !CS,  exp_error: CS,   exp_writes: 0};
        vecs[3] = '{n: 1,         gap: 50, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: 1};
        vecs[4] = '{n: DEPTH,     gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_writes: DEPTH};
        vecs[5] = '{n: DEPTH + 1, gap: 0,  bad: 1'b0, exp_done: 1'b0, exp_error: 1'b1, exp_writes: 0};
        vecs[6] = '{n: 3,         gap: 30, bad: 1'b1, exp_done: !CS,  exp_error: CS,   exp_writes: 3};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // Reference image from the bring-up note.
        spec2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        if (CS) spec2.push_back(8'h00);
        run_load("spec2", spec2, 0, -1);
        if (wr_data_q.size() == 2) begin
            check("spec2 word0", wr_data_q[0], 32'h12345678);
            check("spec2 word1", wr_data_q[1], 32'h9ABCDEF0);
        end
        run_load("spec2 gaps+start", spec2, 50, 5);

        q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        if (CS) q.push_back(8'h04);
        run_load("one word", q, 0, -1);
        if (wr_data_q.size() == 1) check("one word data", wr_data_q[0], 32'h01020304);
        if (CS) begin
            q[6] = 8'h05;
            run_load("one word bad csum", q, 0, -1);
        end

        foreach (vecs[i]) begin
            build(vecs[i].n, vecs[i].bad, q);
            run_load($sformatf("vec%0d", i), q, vecs[i].gap, -1);
            check("vec done", 32'(bus.done), 32'(vecs[i].exp_done));
            check("vec error", 32'(bus.error), 32'(vecs[i].exp_error));
            check("vec writes", wr_addr_q.size(), vecs[i].exp_writes);
        end

        // A restart out of ERROR must clear error and raise busy.
        build(DEPTH + 1, 1'b0, q);
        run_load("oversize", q, 0, -1);
        pulse_start();
        check("restart error", 32'(bus.error), 32'd0);
        check("restart busy", 32'(bus.busy), 32'd1);
        q = '{8'h00, 8'h00};
        if (CS) q.push_back(8'h00);
        wr_addr_q = {};
        wr_data_q = {};
        send_bytes(q, 0, -1);
        repeat (3) @(negedge clk);
        check_load("restart", q);

        // Reset after six data bytes of a three-word image.
        wr_addr_q = {};
        wr_data_q = {};
        q = '{8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        pulse_start();
        send_bytes(q, 0, -1);
        rst = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset writes", wr_addr_q.size(), 1);
        if (wr_data_q.size() >= 1) check("midreset line0", wr_data_q[0], 32'hA1A2A3A4);
        check("midreset idle busy", 32'(bus.busy), 32'd0);

        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(9))
                7:       n = DEPTH;
                8:       n = DEPTH + 1;
                9:       n = int'($urandom_range(300, DEPTH + 2));
                default: n = int'($urandom_range(6));
            endcase
            build(n, 1'($urandom_range(1)), q);
            run_load($sformatf("rand%0d", r), q, int'($urandom_range(60)), -1);
        end

        check("write protocol violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
